// File: rtl/hs_rand_staller.sv
// hs_rand_staller: LFSR-driven stall/burst injector for a rdy/ack handshake channel.
// Withholds the handshake only between transfers, so a presented beat is never withdrawn.
module hs_rand_staller #(
   parameter int          DATA_W    = 32,
   parameter int          STALL_MIN = 0,
   parameter int          STALL_MAX = 4,
   parameter int          BURST_MIN = 1,
   parameter int          BURST_MAX = 3,
   parameter logic [31:0] SEED      = 32'h1,
   parameter int          CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              in_rdy,
   output logic              in_ack,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_rdy,
   input  logic              out_ack,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stat_xfers,
   output logic [CNT_W-1:0]  stat_stalls
);
   if (SEED == 32'd0 || STALL_MIN < 0 || STALL_MAX < STALL_MIN || STALL_MAX > 65535 ||
       BURST_MIN < 1 || BURST_MAX < BURST_MIN || BURST_MAX > 65535) begin : g_bad_param
      $error("hs_rand_staller: illegal parameter set");
   end

   typedef enum logic {PASS, STALL} state_t;

   localparam logic [16:0] SR   = 17'(STALL_MAX - STALL_MIN + 1);
   localparam logic [16:0] BR   = 17'(BURST_MAX - BURST_MIN + 1);
   localparam logic [16:0] SMIN = 17'(STALL_MIN);
   localparam logic [16:0] BMIN = 17'(BURST_MIN);

   state_t      state, state_n;
   logic [15:0] scnt, scnt_n, bcnt, bcnt_n, bcnt_e, s_draw, b_draw;
   logic [16:0] s_mod, b_mod;
   logic [31:0] lfsr;
   logic        en_q, xfer, smp, rise, fall;

   assign out_rdy  = (state == PASS) & in_rdy;
   assign in_ack   = (state == PASS) & out_ack;
   assign out_data = in_data;
   assign xfer     = out_rdy & out_ack;
   // en may only change between beats, never while one is waiting
   assign smp      = ~in_rdy | xfer;
   assign rise     = smp & en & ~en_q;
   assign fall     = smp & ~en & en_q;

   always_comb begin
      s_mod  = (SR == 17'd1) ? 17'd0 : {1'b0, lfsr[15:0]} % SR;
      b_mod  = (BR == 17'd1) ? 17'd0 : {1'b0, lfsr[31:16]} % BR;
      s_draw = 16'(SMIN + s_mod);
      b_draw = 16'(BMIN + b_mod);
   end

   always_comb begin
      state_n = state;
      scnt_n  = scnt;
      bcnt_n  = bcnt;
      bcnt_e  = rise ? b_draw : bcnt;
      if (fall)
         state_n = PASS;
      else if (en_q || rise || state == STALL) begin
         if (state == STALL) begin
            scnt_n  = scnt - 16'd1;
            bcnt_n  = bcnt_e;
            state_n = (scnt == 16'd1) ? PASS : STALL;
         end else if (xfer && bcnt_e == 16'd1) begin
            bcnt_n  = b_draw;
            scnt_n  = s_draw;
            state_n = (s_draw == 16'd0) ? PASS : STALL;
         end else
            bcnt_n = xfer ? bcnt_e - 16'd1 : bcnt_e;
      end
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state       <= (STALL_MAX == 0) ? PASS : STALL;
         scnt        <= 16'(STALL_MAX);
         bcnt        <= 16'(BURST_MAX);
         lfsr        <= SEED;
         en_q        <= 1'b0;
         stat_xfers  <= '0;
         stat_stalls <= '0;
      end else begin
         state <= state_n;
         scnt  <= scnt_n;
         bcnt  <= bcnt_n;
         lfsr  <= lfsr[0] ? (lfsr >> 1) ^ 32'h80200003 : lfsr >> 1;
         en_q  <= smp ? en : en_q;
         if (xfer && !(&stat_xfers))
            stat_xfers <= stat_xfers + 1'b1;
         if (state == STALL && in_rdy && !(&stat_stalls))
            stat_stalls <= stat_stalls + 1'b1;
      end
endmodule

// File: tb/tb_hs_rand_staller.sv
// tb_hs_rand_staller: directed checks of burst/stall pattern, enable, seed traces, saturation and reset.
module tb_hs_rand_staller;
   logic        clk, rstn, en, in_rdy, out_ack;
   logic [31:0] in_data;
   int          n_tests = 0, n_fail = 0, exp_xf;
   logic [13:0] seed1_tr;

   logic        u0_rdy, u0_ack, u1_rdy, u1_ack, u2_rdy, u2_ack, u3_rdy, u3_ack, u4_rdy, u4_ack;
   logic [31:0] u0_d, u1_d, u2_d, u3_d, u4_d;
   logic [15:0] u0_xf, u0_st, u1_xf, u1_st, u2_xf, u2_st, u3_xf, u3_st;
   logic [3:0]  u4_xf, u4_st;

   hs_rand_staller #(.STALL_MIN(2), .STALL_MAX(2), .BURST_MIN(3), .BURST_MAX(3)) u0 (
      .clk(clk), .rstn(rstn), .en(en), .in_rdy(in_rdy), .in_ack(u0_ack), .in_data(in_data),
      .out_rdy(u0_rdy), .out_ack(out_ack), .out_data(u0_d), .stat_xfers(u0_xf), .stat_stalls(u0_st));
   hs_rand_staller #(.SEED(32'h1)) u1 (
      .clk(clk), .rstn(rstn), .en(en), .in_rdy(in_rdy), .in_ack(u1_ack), .in_data(in_data),
      .out_rdy(u1_rdy), .out_ack(out_ack), .out_data(u1_d), .stat_xfers(u1_xf), .stat_stalls(u1_st));
   hs_rand_staller #(.SEED(32'hACE1)) u2 (
      .clk(clk), .rstn(rstn), .en(en), .in_rdy(in_rdy), .in_ack(u2_ack), .in_data(in_data),
      .out_rdy(u2_rdy), .out_ack(out_ack), .out_data(u2_d), .stat_xfers(u2_xf), .stat_stalls(u2_st));
   hs_rand_staller #(.STALL_MIN(0), .STALL_MAX(0)) u3 (
      .clk(clk), .rstn(rstn), .en(en), .in_rdy(in_rdy), .in_ack(u3_ack), .in_data(in_data),
      .out_rdy(u3_rdy), .out_ack(out_ack), .out_data(u3_d), .stat_xfers(u3_xf), .stat_stalls(u3_st));
   hs_rand_staller #(.STALL_MIN(0), .STALL_MAX(0), .CNT_W(4)) u4 (
      .clk(clk), .rstn(rstn), .en(en), .in_rdy(in_rdy), .in_ack(u4_ack), .in_data(in_data),
      .out_rdy(u4_rdy), .out_ack(out_ack), .out_data(u4_d), .stat_xfers(u4_xf), .stat_stalls(u4_st));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // SEED=1 default ranges: 4 stall, 2 xfer, 2 stall, 1 xfer, 4 stall, then pass
      seed1_tr = 14'b10000100110000;
      rstn = 1'b0; en = 1'b1; in_rdy = 1'b1; out_ack = 1'b1; in_data = 32'hA5A5_0001;
      repeat (2) @(negedge clk);
      chk1("rst_rdy", u0_rdy, 1'b0);
      chk1("rst_ack", u0_ack, 1'b0);
      chkn("rst_xfers", 32'(u0_xf), 0);
      chkn("rst_stalls", 32'(u0_st), 0);
      chkn("data_path", u0_d, 32'hA5A5_0001);

      rstn = 1'b1; #1;
      for (int k = 1; k <= 1000; k++) begin
         if (k <= 20) chk1("pattern", u0_rdy, k >= 3 && (k - 3) % 5 < 3);
         if (k <= 14) chk1("seed1_trace", u1_rdy, seed1_tr[k-1]);
         if (k == 7) chk1("seedace_c7", u2_rdy, 1'b0);
         if (k == 8) chk1("seedace_c8", u2_rdy, 1'b1);
         @(posedge clk); @(negedge clk);
         if (k == 20) begin
            chkn("xfers20", 32'(u0_xf), 12);
            chkn("stalls20", 32'(u0_st), 8);
            chkn("sat_xfers", 32'(u4_xf), 15);
            chkn("nostall_xfers20", 32'(u3_xf), 20);
         end
      end
      chkn("xfers1000", 32'(u0_xf), 600);
      chkn("stalls1000", 32'(u0_st), 400);
      chkn("nostall_stalls", 32'(u3_st), 0);
      chkn("nostall_xfers", 32'(u3_xf), 1000);
      chkn("sat_hold", 32'(u4_xf), 15);

      repeat (2) begin @(posedge clk); @(negedge clk); end
      chk1("pre_rst_rdy", u0_rdy, 1'b1);
      rstn = 1'b0; #1;
      chk1("async_rst_rdy", u0_rdy, 1'b0);
      chk1("async_rst_ack", u0_ack, 1'b0);
      chkn("async_rst_xf", 32'(u0_xf), 0);
      chkn("async_rst_st", 32'(u0_st), 0);
      chkn("async_rst_sat", 32'(u4_xf), 0);

      // consumer back-pressure in the middle of a burst
      @(negedge clk); rstn = 1'b1; in_data = 32'h1234_5678;
      for (int k = 1; k <= 13; k++) begin
         out_ack = !(k >= 4 && k <= 8); #1;
         chk1("hold_rdy", u0_rdy, (k >= 3 && k <= 10) || k == 13);
         if (k >= 4 && k <= 8) begin
            chk1("hold_ack", u0_ack, 1'b0);
            chkn("hold_data", u0_d, 32'h1234_5678);
         end
         @(posedge clk); @(negedge clk);
      end
      chkn("hold_xfers", 32'(u0_xf), 4);
      chkn("hold_stalls", 32'(u0_st), 4);

      // en falls on the last transfer of a burst, rises again three beats later
      rstn = 1'b0; @(negedge clk); rstn = 1'b1; out_ack = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         en = !(k >= 5 && k <= 7); #1;
         chk1("enfall_rdy", u0_rdy, k >= 3 && k <= 10);
         @(posedge clk); @(negedge clk);
      end
      chkn("enfall_xfers", 32'(u0_xf), 8);
      chkn("enfall_stalls", 32'(u0_st), 4);

      // bypass with en held low and random handshakes
      rstn = 1'b0; en = 1'b0; @(negedge clk); rstn = 1'b1; exp_xf = 0;
      for (int k = 1; k <= 52; k++) begin
         in_rdy  = (k <= 2) ? 1'b1 : 1'($urandom_range(1));
         out_ack = 1'($urandom_range(1)); #1;
         if (k <= 2) chk1("byp_init_rdy", u0_rdy, 1'b0);
         else begin
            chk1("byp_rdy", u0_rdy, in_rdy);
            chk1("byp_ack", u0_ack, out_ack);
            if (in_rdy && out_ack) exp_xf++;
         end
         @(posedge clk); @(negedge clk);
      end
      chkn("byp_stalls", 32'(u0_st), 2);
      chkn("byp_xfers", 32'(u0_xf), exp_xf);

      // rerun of the seed stimulus must reproduce the same trace
      rstn = 1'b0; @(negedge clk); rstn = 1'b1; en = 1'b1; in_rdy = 1'b1; out_ack = 1'b1; #1;
      for (int k = 1; k <= 14; k++) begin
         chk1("seed1_rerun", u1_rdy, seed1_tr[k-1]);
         if (k == 8) chk1("seedace_rerun", u2_rdy, 1'b1);
         @(posedge clk); @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
